// File: rtl/ahb_aer_xmt_buf_pkg.sv
// Shared constants for the AHB AER transmit buffer: register map, AHB encodings, CTRL bits
// and the data-phase state type.
package ahb_aer_pkg;

    // Register index is addr[4:3]; byte offsets 0x00/0x08/0x10/0x18
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam int unsigned CTRL_DRAIN  = 0;
    localparam int unsigned CTRL_FLUSH  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    typedef enum logic [1:0] {DP_IDLE, DP_WAIT, DP_ERR1, DP_ERR2} dp_state_e;

endpackage

// File: rtl/ahb_aer_xmt_buf_sync_fifo.sv
// Show-ahead synchronous FIFO with push/pop/flush and an occupancy count one bit wider than
// the pointers so that full is level == DEPTH.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal alongside a pop that frees the slot
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ahb_aer_xmt_buf.sv
// AHB-Lite slave that buffers AER event words in a FIFO and streams them to the AER
// transmitter; AHB peripheral_in modport signals appear here as flat ports.
module ahb_aer_xmt_buf
    import ahb_aer_pkg::*;
#(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned EWIDTH = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic [AWIDTH-1:0] addr,
    input  logic              write,
    input  logic [2:0]        size,
    input  logic [1:0]        trans,
    input  logic              ready,
    input  logic [DWIDTH-1:0] wdata,
    output logic              ready_out,
    output logic              resp,
    output logic [DWIDTH-1:0] rdata,
    output logic [EWIDTH-1:0] aer_data_o,
    output logic              aer_valid_o,
    input  logic              aer_ready_i,
    output logic              irq_o
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    dp_state_e         state;
    logic [1:0]        dp_reg;
    logic              dp_write;
    logic [DWIDTH-1:0] rdata_q;
    logic              drain_en;
    logic              irq_en;
    logic [LW-1:0]     thresh;
    logic              valid_q;
    logic              irq_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [LW-1:0]     level;
    logic [LW-1:0]     level_next;
    logic [EWIDTH-1:0] head;

    logic              addr_ok;
    logic              addr_err;
    logic              pop;
    logic              stall;
    logic              wr_done;
    logic              push;
    logic              ctrl_wr;
    logic              flush;
    logic              drain_next;
    logic [DWIDTH-1:0] rd_val;
    logic              unused_bits;

    assign addr_ok  = sel && trans[1] && ready;
    assign addr_err = (size != HSIZE_DWORD) || (addr[AWIDTH-1:5] != '0);
    assign pop      = valid_q && aer_ready_i;
    // DATA write into a full FIFO waits until the transmitter takes a word this same cycle
    assign stall    = (state == DP_WAIT) && dp_write && (dp_reg == REG_DATA) && fifo_full && !pop;

    assign ready_out = (state != DP_ERR1) && !stall;
    assign resp      = (state == DP_ERR1 || state == DP_ERR2) ? HRESP_ERROR : HRESP_OKAY;

    assign wr_done    = (state == DP_WAIT) && dp_write && !stall;
    assign push       = wr_done && (dp_reg == REG_DATA);
    assign ctrl_wr    = wr_done && (dp_reg == REG_CTRL);
    assign flush      = ctrl_wr && wdata[CTRL_FLUSH];
    assign drain_next = ctrl_wr ? wdata[CTRL_DRAIN] : drain_en;

    assign unused_bits = ^{addr[2:0], trans[0], wdata};

    sync_fifo #(
        .WIDTH (EWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata[EWIDTH-1:0]),
        .pop   (pop),
        .flush (flush),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    always_comb begin
        rd_val = '0;
        case (addr[4:3])
            REG_STATUS: begin
                rd_val[2 +: LW] = level;
                rd_val[1]       = fifo_full;
                rd_val[0]       = fifo_empty;
            end
            REG_CTRL: begin
                rd_val[CTRL_DRAIN]  = drain_en;
                rd_val[CTRL_IRQ_EN] = irq_en;
            end
            REG_THRESH: rd_val[LW-1:0] = thresh;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DP_IDLE;
            dp_reg   <= REG_DATA;
            dp_write <= 1'b0;
            rdata_q  <= '0;
        end else if (state == DP_ERR1) begin
            state <= DP_ERR2;
        end else if (ready_out) begin
            if (addr_ok) begin
                state    <= addr_err ? DP_ERR1 : DP_WAIT;
                dp_reg   <= addr[4:3];
                dp_write <= write;
                // Read data is captured at the address edge, so it reflects pre-update state
                if (!addr_err && !write) begin
                    rdata_q <= rd_val;
                end
            end else begin
                state <= DP_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_en <= 1'b0;
            irq_en   <= 1'b0;
            thresh   <= '0;
        end else if (wr_done) begin
            if (dp_reg == REG_CTRL) begin
                drain_en <= wdata[CTRL_DRAIN];
                irq_en   <= wdata[CTRL_IRQ_EN];
            end
            if (dp_reg == REG_THRESH) begin
                thresh <= wdata[LW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (valid_q && !aer_ready_i) begin
                valid_q <= 1'b1;
            end else begin
                valid_q <= drain_next && (level_next != '0);
            end
            irq_q <= irq_en && (level <= thresh);
        end
    end

    assign rdata       = rdata_q;
    assign aer_data_o  = head;
    assign aer_valid_o = valid_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_ahb_aer_xmt_buf.sv
// Randomised bench for ahb_aer_xmt_buf: a queue-based reference model predicts every bus and
// stream output each cycle, with directed scenarios followed by a random transaction mix.
module tb_ahb_aer_xmt_buf;
    import ahb_aer_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic        ready;
    logic [63:0] wdata;
    logic        ready_out;
    logic        resp;
    logic [63:0] rdata;
    logic [31:0] aer_data_o;
    logic        aer_valid_o;
    logic        aer_ready_i = 1'b0;
    logic        irq_o;

    logic        rand_rdy = 1'b0;
    logic        fixed_rdy = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    assign ready = ready_out;

    ahb_aer_xmt_buf #(
        .AWIDTH (32),
        .DWIDTH (64),
        .EWIDTH (32),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .addr        (addr),
        .write       (write),
        .size        (size),
        .trans       (trans),
        .ready       (ready),
        .wdata       (wdata),
        .ready_out   (ready_out),
        .resp        (resp),
        .rdata       (rdata),
        .aer_data_o  (aer_data_o),
        .aer_valid_o (aer_valid_o),
        .aer_ready_i (aer_ready_i),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #1;
        aer_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bus phase, event queue and register contents
    typedef enum int {M_NONE, M_OK, M_ERR1, M_ERR2} mphase_e;
    mphase_e     m_phase;
    logic [1:0]  m_reg;
    logic        m_write;
    logic [31:0] m_q[$];
    logic        m_drain;
    logic        m_irq_en;
    int          m_thresh;
    logic        m_valid;
    logic        m_irq;
    logic [63:0] m_rdata;

    function automatic logic m_pop();
        return m_valid && aer_ready_i;
    endfunction

    function automatic logic m_ready();
        if (m_phase == M_ERR1) return 1'b0;
        if (m_phase == M_OK && m_write && m_reg == 2'd0 && m_q.size() == DEPTH && !m_pop())
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] m_read(input logic [1:0] r);
        case (r)
            2'd1: return 64'(m_q.size()) * 4 + ((m_q.size() == DEPTH) ? 2 : 0)
                         + ((m_q.size() == 0) ? 1 : 0);
            2'd2: return (m_irq_en ? 64'd4 : 64'd0) + (m_drain ? 64'd1 : 64'd0);
            2'd3: return 64'(m_thresh);
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model_upd
        logic rdy, pop, flush, acc, err, done, irq_nx;
        if (rst) begin
            m_phase  = M_NONE;
            m_reg    = 2'd0;
            m_write  = 1'b0;
            m_q.delete();
            m_drain  = 1'b0;
            m_irq_en = 1'b0;
            m_thresh = 0;
            m_valid  = 1'b0;
            m_irq    = 1'b0;
            m_rdata  = 64'd0;
        end else begin
            rdy    = m_ready();
            pop    = m_pop();
            flush  = 1'b0;
            irq_nx = m_irq_en && (m_q.size() <= m_thresh);
            acc    = sel && trans[1] && rdy;
            err    = (size != 3'b011) || (addr[31:5] != 27'd0);
            done   = (m_phase == M_OK) && rdy;
            if (acc && !err && !write) m_rdata = m_read(addr[4:3]);
            if (pop) void'(m_q.pop_front());
            if (done && m_write) begin
                case (m_reg)
                    2'd0: m_q.push_back(wdata[31:0]);
                    2'd2: begin
                        m_drain  = wdata[0];
                        m_irq_en = wdata[2];
                        if (wdata[1]) begin
                            m_q.delete();
                            flush = 1'b1;
                        end
                    end
                    2'd3: m_thresh = int'(wdata[4:0]);
                    default: ;
                endcase
            end
            if (flush) m_valid = 1'b0;
            else if (m_valid && !aer_ready_i) m_valid = 1'b1;
            else m_valid = m_drain && (m_q.size() > 0);
            m_irq = irq_nx;
            if (m_phase == M_ERR1) begin
                m_phase = M_ERR2;
            end else if (rdy) begin
                if (acc) begin
                    m_phase = err ? M_ERR1 : M_OK;
                    m_reg   = addr[4:3];
                    m_write = write;
                end else begin
                    m_phase = M_NONE;
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            check_eq("ready_out", ready_out, m_ready());
            check_eq("resp", resp, (m_phase == M_ERR1 || m_phase == M_ERR2));
            check_eq("aer_valid", aer_valid_o, m_valid);
            if (m_valid) check_eq("aer_data", aer_data_o, m_q[0]);
            check_eq("irq", irq_o, m_irq);
            if (m_phase == M_OK && !m_write) check_eq("rdata", rdata, m_rdata);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready_out"}, ready_out, 1);
        check_eq({tag, "_resp"}, resp, 0);
        check_eq({tag, "_rdata"}, rdata, 0);
        check_eq({tag, "_aer_valid"}, aer_valid_o, 0);
        check_eq({tag, "_aer_data"}, aer_data_o, 0);
        check_eq({tag, "_irq"}, irq_o, 0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        #2;
        while (!ready_out && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 200) check_eq(tag, ready_out, 1);
        @(posedge clk);
    endtask

    // Entered and left on a falling edge; one address phase then its data phase
    task automatic xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                        input logic [63:0] wd);
        sel   = 1'b1;
        trans = HTRANS_NONSEQ;
        addr  = a;
        write = wr;
        size  = sz;
        wait_ready("addr_phase_timeout");
        @(negedge clk);
        sel   = 1'b0;
        trans = HTRANS_IDLE;
        wdata = wd;
        wait_ready("data_phase_timeout");
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [63:0] wd);
        xfer(a, 1'b1, 3'b011, wd);
    endtask

    task automatic rd_reg(input logic [31:0] a);
        xfer(a, 1'b0, 3'b011, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; trans = HTRANS_IDLE; addr = 0; write = 0; size = 3'b011; wdata = 0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Single push drains straight to the transmitter
        fixed_rdy = 1'b1;
        wr_reg(32'h10, 64'h1);
        wr_reg(32'h00, 64'hA5A5_0001);
        repeat (3) @(negedge clk);
        rd_reg(32'h08);

        // Fill to full, then a 17th write stalls until a single pop
        fixed_rdy = 1'b0;
        wr_reg(32'h10, 64'h0);
        for (int i = 0; i < 16; i++) wr_reg(32'h00, {$urandom, $urandom});
        rd_reg(32'h08);
        wr_reg(32'h10, 64'h1);
        fork
            wr_reg(32'h00, 64'hDEAD_0017);
            begin
                repeat (4) @(negedge clk);
                fixed_rdy = 1'b1;
                @(negedge clk);
                fixed_rdy = 1'b0;
            end
        join
        rd_reg(32'h08);

        // Error responses leave state alone
        rd_reg(32'h20);
        xfer(32'h08, 1'b1, 3'b010, 64'hFF);
        xfer(32'h1000_0010, 1'b1, 3'b011, 64'h2);
        rd_reg(32'h08);

        // Low-watermark interrupt while draining
        wr_reg(32'h10, 64'h2);
        wr_reg(32'h18, 64'h2);
        for (int i = 0; i < 4; i++) wr_reg(32'h00, 64'(32'hC0DE_0000 + i));
        wr_reg(32'h10, 64'h5);
        fixed_rdy = 1'b1;
        repeat (8) @(negedge clk);
        rd_reg(32'h10);
        wr_reg(32'h10, 64'h7);
        rd_reg(32'h10);
        rd_reg(32'h18);

        // Valid holds across drain_en clear, flush withdraws it
        fixed_rdy = 1'b0;
        wr_reg(32'h10, 64'h1);
        for (int i = 0; i < 3; i++) wr_reg(32'h00, 64'(32'h5500_0000 + i));
        wr_reg(32'h10, 64'h0);
        repeat (3) @(negedge clk);
        wr_reg(32'h10, 64'h2);
        rd_reg(32'h08);
        rd_reg(32'h00);

        // Reset in the middle of a stalled write
        for (int i = 0; i < 16; i++) wr_reg(32'h00, 64'(32'h7700_0000 + i));
        sel = 1'b1; trans = HTRANS_NONSEQ; addr = 32'h0; write = 1'b1; size = 3'b011;
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0; trans = HTRANS_IDLE; wdata = 64'h1234;
        #2;
        check_eq("stall_before_reset", ready_out, 0);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        wr_reg(32'h00, 64'h0000_0000_BEEF_0001);
        rd_reg(32'h08);

        // Random traffic with a randomly stalling transmitter
        rand_rdy = 1'b1;
        wr_reg(32'h10, 64'h1);
        for (int i = 0; i < 300; i++) begin
            int k;
            k = int'($urandom_range(0, 9));
            if (k <= 4) begin
                wr_reg(32'h00, {$urandom, $urandom});
            end else if (k == 5) begin
                rd_reg(32'h08);
            end else if (k == 6) begin
                wr_reg(32'h10, 64'(($urandom_range(0, 1) << 2)
                                   | (($urandom_range(0, 3) == 0 ? 1 : 0) << 1) | 1));
            end else if (k == 7) begin
                wr_reg(32'h18, {$urandom, $urandom});
            end else if (k == 8) begin
                rd_reg(32'($urandom_range(0, 3) << 3));
            end else begin
                if ($urandom_range(0, 1) == 1)
                    xfer(32'($urandom_range(0, 3) << 3), 1'($urandom_range(0, 1)),
                         3'($urandom_range(4, 7)), 64'h1);
                else
                    xfer(32'(($urandom_range(1, 255) << 5) | ($urandom_range(0, 3) << 3)),
                         1'($urandom_range(0, 1)), 3'b011, 64'h3);
            end
        end
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
